run_limit_stuffer: RTL

- Transmit-side partner of the consecutive-bit run detector.
- Accepts 4-bit parallel words over a valid/ready handshake and serializes them MSB-first onto a 1-bit valid/ready stream.
- Inserts a complement "stuff" bit whenever the transmitted stream reaches MAX_RUN equal consecutive bits, so the output never carries a run longer than MAX_RUN.
- Sits between the word source and the serial line driver.

---
 rtl/rls_pkg.sv | 12 +
 rtl/run_limit_stuffer_if.sv | 21 ++
 rtl/rls_run_tracker.sv | 50 +++++
 rtl/run_limit_stuffer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/rls_pkg.sv
// Shared types and constants for the run-limit bit stuffer.
package rls_pkg;

    localparam int WORD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2
    } rls_state_e;

endpackage

// File: rtl/run_limit_stuffer_if.sv
// Word-in / bit-out handshake bundle for run_limit_stuffer.
interface run_limit_stuffer_if;
    import rls_pkg::*;

    logic [WORD_W-1:0] in_word;
    logic              in_valid;
    logic              in_ready;
    logic              out_bit;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_bit, out_valid
    );

    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_bit, out_valid
    );
endinterface

// File: rtl/rls_run_tracker.sv
// Tracks the last transmitted bit and its run length; flags when the bit
// being offered would complete a run of MAX_RUN and so needs a stuff bit.
module rls_run_tracker #(
    parameter  int MAX_RUN = 2,
    localparam int RUN_W   = $clog2(MAX_RUN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_bit,
    input  logic             accept,
    output logic             last_bit,
    output logic [RUN_W-1:0] run_len_next,
    output logic             stuff_needed
);

    logic             last_bit_r;
    logic [RUN_W-1:0] run_len_r;
    // One extra bit so that MAX_RUN=1 (a stuff bit followed by an equal
    // data bit) can express a run of 2 without wrapping.
    logic [RUN_W:0]   run_inc_s;

    // Next run length if tx_bit is accepted this cycle.
    always_comb begin
        run_inc_s = {{RUN_W{1'b0}}, 1'b1};
        if ((run_len_r != {RUN_W{1'b0}}) && (tx_bit == last_bit_r)) begin
            run_inc_s = {1'b0, run_len_r} + {{RUN_W{1'b0}}, 1'b1};
        end else begin
            run_inc_s = {{RUN_W{1'b0}}, 1'b1};
        end
    end

    assign stuff_needed = (run_inc_s >= (RUN_W + 1)'(MAX_RUN));
    assign run_len_next = stuff_needed ? RUN_W'(MAX_RUN) : run_inc_s[RUN_W-1:0];
    assign last_bit     = last_bit_r;

    // Run history register, updated on every accepted output bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_bit_r <= 1'b0;
            run_len_r  <= {RUN_W{1'b0}};
        end else if (accept) begin
            last_bit_r <= tx_bit;
            run_len_r  <= run_len_next;
        end else begin
            last_bit_r <= last_bit_r;
            run_len_r  <= run_len_r;
        end
    end

endmodule

// File: rtl/run_limit_stuffer.sv
// MSB-first word serializer that inserts complement stuff bits so the output
// never repeats a bit more than MAX_RUN times. Option: RLS_STUFF_CNT_EN.
module run_limit_stuffer
    import rls_pkg::*;
#(
    parameter int MAX_RUN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    run_limit_stuffer_if.slave   bus
`ifdef RLS_STUFF_CNT_EN
    ,
    output logic [7:0]           stuff_cnt
`endif
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);

    rls_state_e        state_r, fsm_state_s, state_next_s;
    logic [WORD_W-1:0] word_r, word_next_s;
    logic [1:0]        bit_idx_r, fsm_idx_s, bit_idx_next_s;
    logic              out_bit_s, out_valid_s, accept_s;
    logic              word_done_s, in_ready_s, load_s;
    logic              last_bit_s, stuff_needed_s;
    logic [RUN_W-1:0]  run_len_next_s;

    rls_run_tracker #(.MAX_RUN(MAX_RUN)) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .tx_bit       (out_bit_s),
        .accept       (accept_s),
        .last_bit     (last_bit_s),
        .run_len_next (run_len_next_s),
        .stuff_needed (stuff_needed_s)
    );

    // Output bit selection from the current state.
    always_comb begin
        out_bit_s = 1'b0;
        case (state_r)
            SHIFT:   out_bit_s = word_r[bit_idx_r];
            STUFF:   out_bit_s = ~last_bit_s;
            default: out_bit_s = 1'b0;
        endcase
    end

    assign out_valid_s = (state_r != IDLE);
    assign accept_s    = out_valid_s && bus.out_ready;

    // Per-state progression for an accepted bit; loading is layered on below.
    always_comb begin
        fsm_state_s = state_r;
        fsm_idx_s   = bit_idx_r;
        word_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                fsm_state_s = IDLE;
            end
            SHIFT: begin
                if (accept_s && stuff_needed_s) begin
                    fsm_state_s = STUFF;
                end else if (accept_s && (bit_idx_r != 2'd0)) begin
                    fsm_idx_s = bit_idx_r - 2'd1;
                end else if (accept_s) begin
                    word_done_s = 1'b1;
                    fsm_state_s = IDLE;
                end else begin
                    fsm_state_s = SHIFT;
                end
            end
            STUFF: begin
                if (accept_s && (bit_idx_r != 2'd0)) begin
                    fsm_idx_s   = bit_idx_r - 2'd1;
                    fsm_state_s = SHIFT;
                end else if (accept_s) begin
                    word_done_s = 1'b1;
                    fsm_state_s = IDLE;
                end else begin
                    fsm_state_s = STUFF;
                end
            end
            default: begin
                fsm_state_s = IDLE;
            end
        endcase
    end

    // A finishing word falls straight through into the next one if offered.
    assign in_ready_s     = (state_r == IDLE) || word_done_s;
    assign load_s         = in_ready_s && bus.in_valid;
    assign state_next_s   = load_s ? SHIFT : fsm_state_s;
    assign bit_idx_next_s = load_s ? 2'd3 : fsm_idx_s;
    assign word_next_s    = load_s ? bus.in_word : word_r;

    // FSM and word holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            word_r    <= {WORD_W{1'b0}};
            bit_idx_r <= 2'd0;
        end else begin
            state_r   <= state_next_s;
            word_r    <= word_next_s;
            bit_idx_r <= bit_idx_next_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_bit   = out_bit_s;
    assign bus.out_valid = out_valid_s;

`ifdef RLS_STUFF_CNT_EN
    // Saturating count of stuff bits that actually left the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            stuff_cnt <= 8'd0;
        end else if (accept_s && (state_r == STUFF) && (stuff_cnt != 8'hFF)) begin
            stuff_cnt <= stuff_cnt + 8'd1;
        end else begin
            stuff_cnt <= stuff_cnt;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^run_len_next_s;
`endif

`ifdef RLS_STUFF_CNT_EN
    logic unused_run_s;
    assign unused_run_s = ^run_len_next_s;
`endif

endmodule
